// File: rtl/tdm_pkg.sv
// Shared types and constants for the 8-slot TDM receive demultiplexer.
package tdm_pkg;

  localparam int TDM_LANES = 8;
  localparam int TDM_SEL_W = 3;

  typedef enum logic {HUNT, RUN} tdm_state_t;

  // Pick lane k out of a one-bit-per-lane frame.
  function automatic logic lane_slice(input logic [TDM_LANES-1:0] frame, input int unsigned k);
    return frame[k[TDM_SEL_W-1:0]];
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: clear, load-to-1 on frame start, increment with natural wrap.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int LANES = TDM_LANES,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [SEL_W-1:0] count,
  output logic             last
);

  logic [SEL_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr)
      count_reg <= '0;
    else if (load1)
      count_reg <= SEL_W'(1);
    else if (inc)
      count_reg <= count_reg + SEL_W'(1);
  end

  assign count = count_reg;
  assign last  = (count_reg == SEL_W'(LANES - 1));

endmodule

// File: rtl/tdm_demux_1x8.sv
// TDM receive demultiplexer: serial slot stream in, one parallel frame per 8 slots out.
// Optional per-lane write strobe output enabled by TDM_DEMUX_LANE_STROBE_EN.
module tdm_demux_1x8
  import tdm_pkg::*;
#(
  parameter int LANES = TDM_LANES,
  parameter int WIDTH = 1,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sync,
  output logic [LANES*WIDTH-1:0] out,
  output logic                   out_valid,
  output logic [SEL_W-1:0]       slot,
  output logic                   locked,
  output logic                   sync_err
`ifdef TDM_DEMUX_LANE_STROBE_EN
  , output logic [LANES-1:0]     lane_we
`endif
);

  tdm_state_t state_reg, state_next;

  logic [WIDTH-1:0]       staging_reg [LANES];
  logic [WIDTH-1:0]       staging_next [LANES];
  logic [LANES*WIDTH-1:0] frame_next;
  logic [LANES*WIDTH-1:0] out_reg;
  logic                   out_valid_reg;
  logic                   sync_err_reg;

  logic [SEL_W-1:0] slot_cnt;
  logic             slot_last;
  logic             wr_en, cnt_load1, cnt_inc, cnt_clr, complete, err;
  logic [SEL_W-1:0] wr_lane;
  logic [LANES-1:0] lane_hit;

  tdm_slot_counter #(.LANES(LANES), .SEL_W(SEL_W)) u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .count (slot_cnt),
    .last  (slot_last)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= HUNT;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (in_valid) begin
      case (state_reg)
        HUNT:    if (in_sync) state_next = RUN;
        RUN:     if (!in_sync && slot_cnt == '0) state_next = HUNT;
        default: state_next = HUNT;
      endcase
    end
  end

  // A sync always starts a frame at lane 0; it is an error only if a frame was in progress.
  always_comb begin
    wr_en     = 1'b0;
    wr_lane   = '0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    complete  = 1'b0;
    err       = 1'b0;
    if (in_valid) begin
      if (in_sync) begin
        wr_en     = 1'b1;
        cnt_load1 = 1'b1;
        err       = (state_reg == RUN) && (slot_cnt != '0);
      end else if (state_reg == RUN) begin
        if (slot_cnt == '0) begin
          err     = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wr_lane  = slot_cnt;
          cnt_inc  = 1'b1;
          complete = slot_last;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_hit[gi]     = wr_en && (wr_lane == SEL_W'(gi));
      assign staging_next[gi] = lane_hit[gi] ? in_data : staging_reg[gi];
      assign frame_next[gi*WIDTH +: WIDTH] = staging_next[gi];
    end
  endgenerate

  // frame_next already carries the final lane, so a completing edge latches it directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      staging_reg   <= '{default: '0};
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      staging_reg   <= staging_next;
      out_valid_reg <= complete;
      sync_err_reg  <= err;
      if (complete)
        out_reg <= frame_next;
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign sync_err  = sync_err_reg;
  assign slot      = slot_cnt;
  assign locked    = (state_reg == RUN);

`ifdef TDM_DEMUX_LANE_STROBE_EN
  logic [LANES-1:0] lane_we_reg;

  always_ff @(posedge clk) begin
    if (rst)
      lane_we_reg <= '0;
    else
      lane_we_reg <= lane_hit;
  end

  assign lane_we = lane_we_reg;
`endif

endmodule

// File: doc/tdm_demux_1x8.md
Name: tdm_demux_1x8

Overview:
- Receive end of an 8-slot time-division link: one serial sample stream in, 8 parallel lanes out.
- Slot 0 of each frame is marked by `in_sync`. Each accepted sample is routed to the lane equal to its slot index.
- When slot 7 is accepted, all 8 samples are presented together as one frame. This is the sequential counterpart of the 8:1 select path in the lab datapath.

Parameters:
- LANES, 8, number of TDM slots/output lanes (power of 2, ≥2)
- WIDTH, 1, bits per slot sample
- SEL_W, $clog2(LANES), slot counter width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  sample present this cycle
- in_data  input  WIDTH  slot sample
- in_sync  input  1  qualifies in_data as slot 0 (meaningful only with in_valid)
- out  output  LANES*WIDTH  last complete frame; lane k at bits [k*WIDTH +: WIDTH]
- out_valid  output  1  one-cycle pulse: `out` updated
- slot  output  SEL_W  next expected slot index
- locked  output  1  high in RUN state
- sync_err  output  1  one-cycle pulse: sync seen mid-frame

Behaviour:
- Reset (rst=1 at edge) forces:
  - out=0, out_valid=0, sync_err=0, slot=0, locked=0
  - internal staging register = 0, state=HUNT
  - Reset mid-frame discards the partial frame.
- State HUNT:
  - in_valid && !in_sync: sample ignored.
  - in_valid && in_sync: in_data written to staging lane 0; slot<=1; go to RUN.
- State RUN:
  - in_valid && !in_sync: in_data written to staging lane `slot`; slot<=slot+1.
  - At slot==LANES-1:
    - out <= staging with lane LANES-1 replaced by in_data; out_valid<=1 next cycle.
    - slot wraps to 0; stay in RUN.
  - in_valid && in_sync with slot==0: normal frame start.
  - in_valid && in_sync with slot!=0:
    - sync_err<=1 for one cycle.
    - Partial frame discarded; out is not updated.
    - in_data taken as lane 0; slot<=1.
  - slot==0 && in_valid && !in_sync: missing sync.
    - sync_err<=1; go to HUNT; slot held 0; sample dropped.
- in_valid=0: all state held; out_valid and sync_err deasserted.
- Latency: out/out_valid visible the cycle after the edge accepting slot LANES-1.
- Between frames, out holds its value. Staging lanes are not cleared; each frame overwrites every lane.
- out_valid and sync_err are never both high, except as follows: missing sync at slot 0 cannot coincide with a completion.
- in_sync without in_valid is ignored.
- Width rule: slot increments modulo LANES; no overflow flag.

Optional Feature:
- Macro: TDM_DEMUX_LANE_STROBE_EN.
- Defined: adds output `lane_we` [LANES], registered and one-hot.
  - Bit k pulses for one cycle after a sample is written to lane k.
  - All zero on reset, in HUNT-dropped samples, and when in_valid=0.
  - Lane 0 bit pulses on the resync sample of a sync_err.
- Undefined: port absent; no logic generated.

Decomposition:
- Package tdm_pkg holds:
  - localparams TDM_LANES=8 and TDM_SEL_W=3
  - typedef enum logic {HUNT, RUN} tdm_state_t
  - function lane_slice(frame, k)
- One sub-module is natural: tdm_slot_counter.
  - SEL_W-bit counter with sync load-to-1, increment, wrap flag and clear.
  - Instantiated once; staging/out registers stay in the top level.

Test Plan:
- Reset hold: rst=1 for 3 cycles with in_valid=1 → out=0, out_valid=0, slot=0, locked=0 throughout; first cycle after release still HUNT.
- Clean frame: sync+samples 1,0,1,1,0,0,1,0 on 8 consecutive valid cycles → out=8'b01001101, out_valid pulse exactly 1 cycle later, slot=0, locked=1.
- Gapped input: same frame with in_valid=0 inserted after slots 2 and 5 → identical out; out_valid 1 cycle after slot 7; no pulses during gaps.
- Early sync: sync at slot 4 → sync_err single pulse, out unchanged from previous frame, new frame from that sample completes correctly 7 samples later.
- Missing sync: after a good frame, valid sample without in_sync → sync_err pulse, locked=0; next 3 non-sync samples ignored; sync relocks.
- Reset mid-frame: rst at slot 5, then full clean frame → only the post-reset frame appears on out. With TDM_DEMUX_LANE_STROBE_EN, check lane_we=8'h01..8'h80 in order during the clean frame.
